perceptron_trainer: RTL and testbench
=====================================

Name: perceptron_trainer

Overview:
- Training stage directly upstream of the perceptron weight table; consumes resolved-branch records from the pipeline and produces one updated weight row plus a single-cycle write enable for the table.
- Reads the current row of the selected perceptron, applies the perceptron rule (train on mispredict or low confidence) over LANES weights per cycle with saturation, then writes the row back.
- Single outstanding training job; valid/ready handshake toward the branch-resolve logic.

Parameters:
- WEIGHT_NUMBER, 65, weights per perceptron (index 0 = bias)
- PERCEPTRON_NUMBER, 64, rows in weight table
- WIDTH, 8, signed weight width
- HISTORY_SIZE, 64, global history bits (= WEIGHT_NUMBER-1)
- Y_WIDTH, 16, signed width of stored perceptron output
- THETA, 137, training threshold (floor(1.93*HISTORY_SIZE+14))
- LANES, 8, weights updated per cycle

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- res_valid  in  1  resolved-branch record valid
- res_ready  out  1  trainer can accept a record
- res_idx  in  $clog2(PERCEPTRON_NUMBER)  perceptron used at prediction
- res_history  in  HISTORY_SIZE  history snapshot at prediction (bit=1 taken)
- res_y  in  Y_WIDTH signed  perceptron output at prediction
- res_taken  in  1  actual outcome
- rd_idx  out  $clog2(PERCEPTRON_NUMBER)  row select toward table
- rd_row  in  WIDTH x WEIGHT_NUMBER signed  current row (combinational from table)
- upd_en  out  1  one-cycle write strobe
- upd_idx  out  $clog2(PERCEPTRON_NUMBER)  row to write
- upd_row  out  WIDTH x WEIGHT_NUMBER signed  new row
- busy  out  1  FSM not in IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: FSM=IDLE, res_ready=1, busy=0, upd_en=0, rd_idx=0, upd_idx=0, upd_row all zero, lane counter=0.
- Handshake: record accepted when res_valid&&res_ready; res_ready=1 only in IDLE. Accepted fields latched.
- Train decision at accept: t=+1 if res_taken else -1; predicted=(res_y>=0); train = (predicted!=res_taken) || (|res_y| <= THETA). |res_y| for most-negative value treated as > THETA (no overflow).
- FSM: IDLE -> (accept & train) LOAD; (accept & !train) stays IDLE, no write.
- LOAD (1 cycle): rd_idx=latched idx; capture rd_row into working row register.
- UPDATE: ceil(WEIGHT_NUMBER/LANES) cycles (9 at defaults); cycle k updates weights k*LANES..k*LANES+LANES-1; lanes beyond WEIGHT_NUMBER-1 ignored.
- Rule: w0 += t; wi += t*xi, xi=+1 if history[i-1]=1 else -1 (i=1..HISTORY_SIZE). Sum computed WIDTH+1 bits, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- WRITE (1 cycle): upd_en=1, upd_idx=latched idx, upd_row=working row; next IDLE. upd_row holds last value afterwards.
- Latency accept->upd_en at defaults: 1+9+1 = 11 cycles; next accept on cycle after WRITE.
- rd_idx held stable LOAD through WRITE.
- res_valid while busy: ignored (res_ready=0); upstream holds record.
- rst asserted mid-job: job discarded, no upd_en, all outputs to reset values.

Optional Feature:
- PERCEPTRON_TRAINER_STATS_EN: adds outputs stat_mispredict, stat_trained, stat_skipped (32-bit, wrap at 2^32, reset 0), incremented on accept. Without macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
- Package perceptron_pkg: WIDTH, WEIGHT_NUMBER, PERCEPTRON_NUMBER, HISTORY_SIZE, Y_WIDTH, THETA, idx_t, weight_t, weight_row_t, trainer_state_e {IDLE, LOAD, UPDATE, WRITE}.
- Sub-module sat_weight_step: combinational single-lane w + delta (+/-1) with saturation, instantiated LANES times.

Test Plan:
- Reset then idle: res_ready=1, busy=0, upd_en never asserts over 20 cycles.
- res_y=+200, res_taken=1 (correct, |y|>137) -> no training, no upd_en, res_ready stays 1.
- res_y=+50, taken=1, history all 1, row all 0, idx=5 -> upd_en exactly 11 cycles after accept, upd_idx=5, all 65 weights=+1.
- res_y=-300, taken=1 (mispredict), history alternating 1/0 from bit0, row all 0 -> w0=+1, w1=+1, w2=-1, w3=+1 ... pattern.
- Saturation: row all +127, taken=1, history all 1 -> all 127; row all -128, taken=0, history all 1 -> all -128.
- rst pulsed during UPDATE -> no upd_en; next record after reset trains normally; res_valid during busy not accepted.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared sizing, types and FSM encoding for the perceptron weight trainer.
package perceptron_pkg;

  localparam int unsigned WEIGHT_NUMBER     = 65;
  localparam int unsigned PERCEPTRON_NUMBER = 64;
  localparam int unsigned WIDTH             = 8;
  localparam int unsigned HISTORY_SIZE      = WEIGHT_NUMBER - 1;
  localparam int unsigned Y_WIDTH           = 16;
  localparam int unsigned THETA             = 137;
  localparam int unsigned LANES             = 8;

  localparam int unsigned IDX_W      = $clog2(PERCEPTRON_NUMBER);
  localparam int unsigned ROW_IW     = $clog2(WEIGHT_NUMBER);
  localparam int unsigned HIST_IW    = $clog2(HISTORY_SIZE);
  localparam int unsigned UPD_CYCLES = (WEIGHT_NUMBER + LANES - 1) / LANES;
  localparam int unsigned LCNT_W     = $clog2(UPD_CYCLES);

  typedef logic [IDX_W-1:0]                idx_t;
  typedef logic signed [WIDTH-1:0]         weight_t;
  typedef weight_t [WEIGHT_NUMBER-1:0]     weight_row_t;
  typedef logic [HISTORY_SIZE-1:0]         history_t;
  typedef logic signed [Y_WIDTH-1:0]       y_t;

  // Fields of an accepted record that the update phase still needs
  typedef struct packed {
    history_t history;
    logic     taken;
  } train_job_t;

  typedef enum logic [1:0] {IDLE, LOAD, UPDATE, WRITE} trainer_state_e;

endpackage

// File: rtl/perceptron_trainer_if.sv
// Resolved-branch record channel (valid/ready) from branch-resolve logic to the trainer.
interface perceptron_trainer_if;
  import perceptron_pkg::*;

  logic     res_valid;
  logic     res_ready;
  idx_t     res_idx;
  history_t res_history;
  y_t       res_y;
  logic     res_taken;

  modport master (output res_valid, res_idx, res_history, res_y, res_taken,
                  input  res_ready);
  modport slave  (input  res_valid, res_idx, res_history, res_y, res_taken,
                  output res_ready);
endinterface

// File: rtl/sat_weight_step.sv
// Single-lane weight step: w +/- 1 computed one bit wider, then clamped to the weight range.
module sat_weight_step
  import perceptron_pkg::*;
(
  input  weight_t w,
  input  logic    up,
  output weight_t w_next_c
);

  logic [WIDTH:0] sum_c;

  always_comb begin
    sum_c    = {w[WIDTH-1], w} + (up ? (WIDTH+1)'(1) : {(WIDTH+1){1'b1}});
    w_next_c = weight_t'(sum_c[WIDTH-1:0]);
    // Top two bits disagree only when the step left the representable range
    if (sum_c[WIDTH] != sum_c[WIDTH-1]) begin
      w_next_c = sum_c[WIDTH] ? weight_t'({1'b1, {(WIDTH-1){1'b0}}})
                              : weight_t'({1'b0, {(WIDTH-1){1'b1}}});
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training stage: read row, apply saturating +/-1 rule LANES weights per cycle, write back.
// Optional counters enabled by defining PERCEPTRON_TRAINER_STATS_EN.
module perceptron_trainer
  import perceptron_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  perceptron_trainer_if.slave res,
  output idx_t                rd_idx,
  input  weight_row_t         rd_row,
  output logic                upd_en,
  output idx_t                upd_idx,
  output weight_row_t         upd_row,
  output logic                busy
`ifdef PERCEPTRON_TRAINER_STATS_EN
  ,
  output logic [31:0]         stat_mispredict,
  output logic [31:0]         stat_trained,
  output logic [31:0]         stat_skipped
`endif
);

  trainer_state_e    state;
  logic [LCNT_W-1:0] lane_cnt;
  train_job_t        job;
  weight_row_t       work;

  logic [Y_WIDTH-1:0] y_mag_c;
  logic               mispredict_c;
  logic               low_conf_c;
  logic               train_c;
  logic               accept_c;

  int unsigned       lane_pos [LANES];
  logic              lane_ok  [LANES];
  logic [ROW_IW-1:0] lane_sel [LANES];
  weight_t           lane_w   [LANES];
  logic              lane_up  [LANES];
  weight_t           lane_out [LANES];

  // Train decision; the most-negative y maps to 2^(Y_WIDTH-1), which is above THETA
  always_comb begin
    y_mag_c      = res.res_y[Y_WIDTH-1] ? (~res.res_y + Y_WIDTH'(1)) : res.res_y;
    mispredict_c = (~res.res_y[Y_WIDTH-1]) != res.res_taken;
    low_conf_c   = y_mag_c <= Y_WIDTH'(THETA);
    train_c      = mispredict_c || low_conf_c;
    accept_c     = res.res_valid && res.res_ready;
  end

  // Lane l of step k handles weight k*LANES+l; bias moves with t, others with t*x
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_pos[l] = 32'(lane_cnt) * LANES + 32'(l);
      lane_ok[l]  = lane_pos[l] < WEIGHT_NUMBER;
      lane_sel[l] = ROW_IW'(lane_pos[l]);
      lane_w[l]   = '0;
      lane_up[l]  = job.taken;
      if (lane_ok[l]) begin
        lane_w[l] = work[lane_sel[l]];
        if (lane_pos[l] != 0) begin
          lane_up[l] = job.taken == job.history[HIST_IW'(lane_pos[l] - 1)];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_weight_step u_step (
      .w        (lane_w[g]),
      .up       (lane_up[g]),
      .w_next_c (lane_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      res.res_ready <= 1'b1;
      busy          <= 1'b0;
      upd_en        <= 1'b0;
      rd_idx        <= '0;
      upd_idx       <= '0;
      upd_row       <= '0;
      lane_cnt      <= '0;
      job           <= '0;
      work          <= '0;
    end else begin
      upd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            job.history <= res.res_history;
            job.taken   <= res.res_taken;
            if (train_c) begin
              rd_idx        <= res.res_idx;
              state         <= LOAD;
              res.res_ready <= 1'b0;
              busy          <= 1'b1;
            end
          end
        end
        LOAD: begin
          work     <= rd_row;
          lane_cnt <= '0;
          state    <= UPDATE;
        end
        UPDATE: begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_ok[l]) work[lane_sel[l]] <= lane_out[l];
          end
          if (lane_cnt == LCNT_W'(UPD_CYCLES - 1)) begin
            lane_cnt <= '0;
            state    <= WRITE;
          end else begin
            lane_cnt <= lane_cnt + LCNT_W'(1);
          end
        end
        WRITE: begin
          upd_en        <= 1'b1;
          upd_idx       <= rd_idx;
          upd_row       <= work;
          state         <= IDLE;
          res.res_ready <= 1'b1;
          busy          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PERCEPTRON_TRAINER_STATS_EN
  // Event counters, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_mispredict <= '0;
      stat_trained    <= '0;
      stat_skipped    <= '0;
    end else if (accept_c) begin
      if (mispredict_c) stat_mispredict <= stat_mispredict + 32'd1;
      if (train_c) stat_trained <= stat_trained + 32'd1;
      else         stat_skipped <= stat_skipped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: directed cases plus random jobs against a table model.
`timescale 1ns/1ps
module tb_perceptron_trainer;
  import perceptron_pkg::*;

  typedef logic [575:0] cv_t;

  logic        clk = 1'b0;
  logic        rst;
  idx_t        rd_idx;
  weight_row_t rd_row;
  logic        upd_en;
  idx_t        upd_idx;
  weight_row_t upd_row;
  logic        busy;
`ifdef PERCEPTRON_TRAINER_STATS_EN
  logic [31:0] stat_mispredict, stat_trained, stat_skipped;
`endif

  perceptron_trainer_if res_if ();

  weight_row_t tbl [PERCEPTRON_NUMBER];
  assign rd_row = tbl[rd_idx];

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  perceptron_trainer dut (
    .clk     (clk),
    .rst     (rst),
    .res     (res_if),
    .rd_idx  (rd_idx),
    .rd_row  (rd_row),
    .upd_en  (upd_en),
    .upd_idx (upd_idx),
    .upd_row (upd_row),
    .busy    (busy)
`ifdef PERCEPTRON_TRAINER_STATS_EN
    ,
    .stat_mispredict (stat_mispredict),
    .stat_trained    (stat_trained),
    .stat_skipped    (stat_skipped)
`endif
  );

  task automatic chk(input string tag, input cv_t obs, input cv_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: perceptron rule over the whole row in plain integer arithmetic
  function automatic weight_row_t model_row(input weight_row_t old, input history_t h, input bit taken);
    weight_row_t r;
    int t    = taken ? 1 : -1;
    int wmax = (1 << (WIDTH - 1)) - 1;
    int wmin = -(1 << (WIDTH - 1));
    for (int i = 0; i < WEIGHT_NUMBER; i++) begin
      weight_t e = old[i];
      int      s = int'(e);
      if (i == 0) s = s + t;
      else        s = s + (h[i-1] ? t : -t);
      if (s > wmax) s = wmax;
      if (s < wmin) s = wmin;
      r[i] = weight_t'(s);
    end
    return r;
  endfunction

  function automatic bit model_train(input int y, input bit taken);
    int a = (y < 0) ? -y : y;
    bit pred = (y >= 0);
    return (pred != taken) || (a <= int'(THETA));
  endfunction

  function automatic weight_row_t rand_row();
    weight_row_t r;
    for (int i = 0; i < WEIGHT_NUMBER; i++) begin
      case ($urandom_range(0, 5))
        0:       r[i] = weight_t'(-128);
        1:       r[i] = weight_t'(127);
        default: r[i] = weight_t'($urandom_range(0, 255));
      endcase
    end
    return r;
  endfunction

  task automatic start_job(input idx_t idx, input history_t h, input int y, input bit taken);
    int c = 0;
    @(negedge clk);
    while (res_if.res_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("ready_before_accept", cv_t'(res_if.res_ready), cv_t'(1'b1));
    res_if.res_idx     = idx;
    res_if.res_history = h;
    res_if.res_y       = y_t'(y);
    res_if.res_taken   = taken;
    res_if.res_valid   = 1'b1;
    @(posedge clk);
    #1;
    res_if.res_valid   = 1'b0;
  endtask

  task automatic finish_job(input idx_t idx, input weight_row_t exp);
    int lat = 0;
    chk("busy_after_accept", cv_t'(busy), cv_t'(1'b1));
    chk("ready_low_after_accept", cv_t'(res_if.res_ready), cv_t'(1'b0));
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (upd_en === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("latency", cv_t'(lat), cv_t'(11));
    chk("upd_idx", cv_t'(upd_idx), cv_t'(idx));
    chk("upd_row", cv_t'(upd_row), cv_t'(exp));
    chk("rd_idx_held", cv_t'(rd_idx), cv_t'(idx));
    chk("ready_after_write", cv_t'(res_if.res_ready), cv_t'(1'b1));
    @(posedge clk);
    #1;
    chk("upd_en_one_cycle", cv_t'(upd_en), cv_t'(1'b0));
    chk("upd_row_holds", cv_t'(upd_row), cv_t'(exp));
    tbl[idx] = exp;
  endtask

  task automatic skip_job();
    logic saw = 1'b0;
    chk("skip_ready", cv_t'(res_if.res_ready), cv_t'(1'b1));
    chk("skip_busy", cv_t'(busy), cv_t'(1'b0));
    repeat (13) begin
      @(posedge clk);
      #1;
      saw |= upd_en;
    end
    chk("skip_no_upd_en", cv_t'(saw), cv_t'(1'b0));
  endtask

  task automatic run_job(input idx_t idx, input history_t h, input int y, input bit taken);
    start_job(idx, h, y, taken);
    if (model_train(y, taken)) finish_job(idx, model_row(tbl[idx], h, taken));
    else                       skip_job();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    weight_row_t exp;
    history_t    h;
    logic        saw;
    int          y;

    rst                = 1'b1;
    res_if.res_valid   = 1'b0;
    res_if.res_idx     = '0;
    res_if.res_history = '0;
    res_if.res_y       = '0;
    res_if.res_taken   = 1'b0;
    for (int r = 0; r < PERCEPTRON_NUMBER; r++) tbl[r] = rand_row();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cv_t'(res_if.res_ready), cv_t'(1'b1));
    chk("rst_busy", cv_t'(busy), cv_t'(1'b0));
    chk("rst_upd_en", cv_t'(upd_en), cv_t'(1'b0));
    chk("rst_rd_idx", cv_t'(rd_idx), cv_t'(0));
    chk("rst_upd_idx", cv_t'(upd_idx), cv_t'(0));
    chk("rst_upd_row", cv_t'(upd_row), cv_t'(0));
    @(negedge clk);
    rst = 1'b0;

    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      saw |= upd_en;
    end
    chk("idle_no_upd_en", cv_t'(saw), cv_t'(1'b0));
    chk("idle_ready", cv_t'(res_if.res_ready), cv_t'(1'b1));

    // Confident correct prediction: no training
    run_job(idx_t'(3), '1, 200, 1'b1);

    // Low confidence, all-taken history, zero row -> every weight +1
    tbl[5] = '0;
    start_job(idx_t'(5), '1, 50, 1'b1);
    for (int i = 0; i < WEIGHT_NUMBER; i++) exp[i] = weight_t'(1);
    finish_job(idx_t'(5), exp);

    // Mispredict with alternating history starting at bit0 = 1
    tbl[7] = '0;
    start_job(idx_t'(7), {32{2'b01}}, -300, 1'b1);
    for (int i = 0; i < WEIGHT_NUMBER; i++)
      exp[i] = (i == 0 || (i % 2) == 1) ? weight_t'(1) : weight_t'(-1);
    finish_job(idx_t'(7), exp);

    // Saturation at both ends
    for (int i = 0; i < WEIGHT_NUMBER; i++) tbl[10][i] = weight_t'(127);
    start_job(idx_t'(10), '1, 50, 1'b1);
    for (int i = 0; i < WEIGHT_NUMBER; i++) exp[i] = weight_t'(127);
    finish_job(idx_t'(10), exp);
    for (int i = 0; i < WEIGHT_NUMBER; i++) tbl[11][i] = weight_t'(-128);
    start_job(idx_t'(11), '1, -50, 1'b0);
    for (int i = 0; i < WEIGHT_NUMBER; i++) exp[i] = weight_t'(-128);
    finish_job(idx_t'(11), exp);

    // Threshold edges and most-negative output
    h = {$urandom, $urandom};
    run_job(idx_t'(20), h, 137, 1'b1);
    run_job(idx_t'(20), h, 138, 1'b1);
    run_job(idx_t'(21), h, -137, 1'b0);
    run_job(idx_t'(21), h, -138, 1'b0);
    run_job(idx_t'(22), h, -32768, 1'b0);
    run_job(idx_t'(22), h, -32768, 1'b1);

    // Records offered while busy are refused; reset mid-update abandons the job
    start_job(idx_t'(9), {$urandom, $urandom}, 50, 1'b1);
    @(negedge clk);
    res_if.res_idx     = idx_t'(12);
    res_if.res_history = {$urandom, $urandom};
    res_if.res_y       = y_t'(-5);
    res_if.res_taken   = 1'b1;
    res_if.res_valid   = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("busy_refuses", cv_t'(res_if.res_ready), cv_t'(1'b0));
      chk("busy_high", cv_t'(busy), cv_t'(1'b1));
    end
    @(negedge clk);
    res_if.res_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready", cv_t'(res_if.res_ready), cv_t'(1'b1));
    chk("midrst_busy", cv_t'(busy), cv_t'(1'b0));
    chk("midrst_rd_idx", cv_t'(rd_idx), cv_t'(0));
    chk("midrst_upd_idx", cv_t'(upd_idx), cv_t'(0));
    chk("midrst_upd_row", cv_t'(upd_row), cv_t'(0));
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      saw |= upd_en;
    end
    chk("midrst_no_upd_en", cv_t'(saw), cv_t'(1'b0));
    run_job(idx_t'(12), {$urandom, $urandom}, -5, 1'b1);

    // Random jobs; small index range so rows accumulate toward saturation
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0:       y = -32768;
        1:       y = 32767;
        2:       y = $urandom_range(0, 1) ? 137 : -137;
        3:       y = $urandom_range(0, 1) ? 138 : -138;
        default: y = int'($urandom_range(0, 800)) - 400;
      endcase
      run_job(idx_t'($urandom_range(0, 7)), {$urandom, $urandom}, y, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
